// File: rtl/slc3_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : slc3_ctrl_fsm
// Purpose  : Moore instruction sequencer (ISDU) for the SLC-3 datapath.
// Revision : 1.0 - initial release
// ============================================================================
module slc3_ctrl_fsm #(
    parameter int MEM_WAIT = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [2:0] c_LAST = 3'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        S_HALTED = 5'd0,  S_F1  = 5'd1,  S_F2  = 5'd2,  S_F3  = 5'd3,
        S_DEC    = 5'd4,  S_ADD = 5'd5,  S_AND = 5'd6,  S_NOT = 5'd7,
        S_BR_T   = 5'd8,  S_JMP = 5'd9,  S_J1  = 5'd10, S_J2  = 5'd11,
        S_L1     = 5'd12, S_L2  = 5'd13, S_L3  = 5'd14, S_S1  = 5'd15,
        S_S2     = 5'd16, S_S3  = 5'd17, S_P1  = 5'd18, S_P2  = 5'd19
    } state_t;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe, mem_we;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    ctrl_t      out_q;

    function automatic ctrl_t decode(input state_t s, input logic [2:0] c,
                                     input logic ir5, input logic ir11);
        ctrl_t o;
        o = '0;
        case (s)
            S_F1: begin
                o.gate_pc = 1'b1; o.ld_mar = 1'b1; o.ld_pc = 1'b1;
            end
            S_F2, S_L2: begin
                o.mem_oe = 1'b1;
                o.ld_mdr = (c == c_LAST);
            end
            S_F3: begin
                o.gate_mdr = 1'b1; o.ld_ir = 1'b1;
            end
            S_DEC: o.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                o.gate_alu = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
                o.sr1mux   = 1'b1; o.sr2mux = ir5;
                o.aluk     = (s == S_ADD) ? 2'd0 : (s == S_AND) ? 2'd1 : 2'd2;
            end
            S_BR_T: begin
                o.ld_pc = 1'b1; o.pcmux = 2'd2; o.addr2mux = 2'd2;
            end
            S_JMP: begin
                o.ld_pc = 1'b1; o.pcmux = 2'd2; o.addr1mux = 1'b1; o.sr1mux = 1'b1;
            end
            S_J1: begin
                o.gate_pc = 1'b1; o.drmux = 1'b1; o.ld_reg = 1'b1;
            end
            S_J2: begin
                o.ld_pc = 1'b1; o.pcmux = 2'd2;
                if (ir11) begin
                    o.addr2mux = 2'd3;
                end else begin
                    o.addr1mux = 1'b1; o.sr1mux = 1'b1;
                end
            end
            S_L1, S_S1: begin
                o.gate_marmux = 1'b1; o.addr1mux = 1'b1; o.addr2mux = 2'd1;
                o.sr1mux      = 1'b1; o.ld_mar   = 1'b1;
            end
            S_L3: begin
                o.gate_mdr = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
            end
            S_S2: begin
                o.aluk = 2'd3; o.gate_alu = 1'b1; o.ld_mdr = 1'b1;
            end
            S_S3: o.mem_we = 1'b1;
            S_P1: o.ld_led = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // The wait counter is zero outside memory states, so every entry starts at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_HALTED: if (Run) state_d = S_F1;
            S_F1:     state_d = S_F2;
            S_F2:     if (cnt_q == c_LAST) state_d = S_F3; else cnt_d = cnt_q + 3'd1;
            S_F3:     state_d = S_DEC;
            S_DEC: begin
                case (Opcode)
                    4'b0001: state_d = S_ADD;
                    4'b0101: state_d = S_AND;
                    4'b1001: state_d = S_NOT;
                    4'b0000: state_d = BEN ? S_BR_T : S_F1;
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = S_J1;
                    4'b0110: state_d = S_L1;
                    4'b0111: state_d = S_S1;
                    4'b1101: state_d = S_P1;
                    default: state_d = S_F1;
                endcase
            end
            S_J1:     state_d = S_J2;
            S_L1:     state_d = S_L2;
            S_L2:     if (cnt_q == c_LAST) state_d = S_L3; else cnt_d = cnt_q + 3'd1;
            S_S1:     state_d = S_S2;
            S_S2:     state_d = S_S3;
            S_S3:     if (cnt_q == c_LAST) state_d = S_F1; else cnt_d = cnt_q + 3'd1;
            S_P1:     if (Continue) state_d = S_P2;
            S_P2:     if (!Continue) state_d = S_F1;
            default:  state_d = S_F1;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_HALTED;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= decode(state_d, cnt_d, IR_5, IR_11);
        end
    end

    assign LD_MAR     = out_q.ld_mar;
    assign LD_MDR     = out_q.ld_mdr;
    assign LD_IR      = out_q.ld_ir;
    assign LD_BEN     = out_q.ld_ben;
    assign LD_CC      = out_q.ld_cc;
    assign LD_REG     = out_q.ld_reg;
    assign LD_PC      = out_q.ld_pc;
    assign LD_LED     = out_q.ld_led;
    assign GatePC     = out_q.gate_pc;
    assign GateMDR    = out_q.gate_mdr;
    assign GateALU    = out_q.gate_alu;
    assign GateMARMUX = out_q.gate_marmux;
    assign PCMUX      = out_q.pcmux;
    assign DRMUX      = out_q.drmux;
    assign SR1MUX     = out_q.sr1mux;
    assign SR2MUX     = out_q.sr2mux;
    assign ADDR1MUX   = out_q.addr1mux;
    assign ADDR2MUX   = out_q.addr2mux;
    assign ALUK       = out_q.aluk;
    assign Mem_OE     = out_q.mem_oe;
    assign Mem_WE     = out_q.mem_we;

endmodule
`default_nettype wire

// File: tb/tb_slc3_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_slc3_ctrl_fsm
// Purpose  : Scoreboard bench for the SLC-3 control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slc3_ctrl_fsm;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = 4'h0;
    logic       IR_5 = 1'b0;
    logic       IR_11 = 1'b0;
    logic       BEN = 1'b0;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

    slc3_ctrl_fsm #(.MEM_WAIT(3)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #10 Clk = ~Clk;

    wire [23:0] w_obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                         GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                         SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    localparam logic [23:0] c_WE = 24'h1,       c_OE = 24'h2;
    localparam logic [23:0] c_ALUK_AND = 24'h4, c_ALUK_NOT = 24'h8, c_ALUK_PASS = 24'hC;
    localparam logic [23:0] c_A2_OFF6 = 24'h10, c_A2_OFF9 = 24'h20, c_A2_OFF11 = 24'h30;
    localparam logic [23:0] c_A1 = 24'h40,      c_SR2 = 24'h80, c_SR1 = 24'h100;
    localparam logic [23:0] c_DR = 24'h200,     c_PC_ADDER = 24'h800;
    localparam logic [23:0] c_GMARMUX = 24'h1000, c_GALU = 24'h2000;
    localparam logic [23:0] c_GMDR = 24'h4000,  c_GPC = 24'h8000;
    localparam logic [23:0] c_LED = 24'h10000,  c_LDPC = 24'h20000, c_LDREG = 24'h40000;
    localparam logic [23:0] c_LDCC = 24'h80000, c_LDBEN = 24'h100000;
    localparam logic [23:0] c_LDIR = 24'h200000, c_LDMDR = 24'h400000, c_LDMAR = 24'h800000;
    localparam logic [23:0] c_F1 = c_GPC | c_LDMAR | c_LDPC;

    logic [23:0] sb[$];
    logic [23:0] exp_v;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Fetch + decode expectations, starting from an observed F1 cycle.
    task automatic push_fetch();
        sb.push_back(c_OE);
        sb.push_back(c_OE);
        sb.push_back(c_OE | c_LDMDR);
        sb.push_back(c_GMDR | c_LDIR);
        sb.push_back(c_LDBEN);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Run   = 1'b0;
        step();
        step();
        n_checks++;
        if (w_obs !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_assert: got %h want %h", w_obs, 24'h0);
        end
        Reset = 1'b0;
        repeat (10) sb.push_back(24'h0);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL halted_hold: got %h want %h", w_obs, exp_v);
            end
        end
    endtask

    task automatic test_start();
        Run = 1'b1;
        sb.push_back(c_F1);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL start_f1: got %h want %h", w_obs, exp_v);
            end
        end
    endtask

    task automatic test_alu(input logic [3:0] op, input logic ir5, input logic [23:0] aluk);
        Opcode = op;
        IR_5   = ir5;
        push_fetch();
        sb.push_back(c_GALU | c_LDREG | c_LDCC | c_SR1 | (ir5 ? c_SR2 : 24'h0) | aluk);
        sb.push_back(c_F1);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL alu_op%b: got %h want %h", op, w_obs, exp_v);
            end
        end
    endtask

    task automatic test_branch(input logic ben);
        Opcode = 4'b0000;
        BEN    = ben;
        push_fetch();
        if (ben) sb.push_back(c_LDPC | c_PC_ADDER | c_A2_OFF9);
        sb.push_back(c_F1);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL branch_ben%b: got %h want %h", ben, w_obs, exp_v);
            end
        end
        BEN = 1'b0;
    endtask

    task automatic test_jumps();
        Opcode = 4'b1100;
        push_fetch();
        sb.push_back(c_LDPC | c_PC_ADDER | c_A1 | c_SR1);
        sb.push_back(c_F1);
        for (int k = 0; k < 2; k++) begin
            while (sb.size() > 0) begin
                step();
                exp_v = sb.pop_front();
                n_checks++;
                if (w_obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL jump_%0d: got %h want %h", k, w_obs, exp_v);
                end
            end
            if (k == 0) begin
                Opcode = 4'b0100;
                IR_11  = 1'b1;
                push_fetch();
                sb.push_back(c_GPC | c_DR | c_LDREG);
                sb.push_back(c_LDPC | c_PC_ADDER | c_A2_OFF11);
                sb.push_back(c_F1);
            end
        end
        Opcode = 4'b0100;
        IR_11  = 1'b0;
        push_fetch();
        sb.push_back(c_GPC | c_DR | c_LDREG);
        sb.push_back(c_LDPC | c_PC_ADDER | c_A1 | c_SR1);
        sb.push_back(c_F1);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL jsrr: got %h want %h", w_obs, exp_v);
            end
        end
    endtask

    task automatic test_ldr_str();
        Opcode = 4'b0110;
        push_fetch();
        sb.push_back(c_GMARMUX | c_A1 | c_A2_OFF6 | c_SR1 | c_LDMAR);
        sb.push_back(c_OE);
        sb.push_back(c_OE);
        sb.push_back(c_OE | c_LDMDR);
        sb.push_back(c_GMDR | c_LDREG | c_LDCC);
        sb.push_back(c_F1);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL ldr: got %h want %h", w_obs, exp_v);
            end
        end
        Opcode = 4'b0111;
        push_fetch();
        sb.push_back(c_GMARMUX | c_A1 | c_A2_OFF6 | c_SR1 | c_LDMAR);
        sb.push_back(c_ALUK_PASS | c_GALU | c_LDMDR);
        repeat (3) sb.push_back(c_WE);
        sb.push_back(c_F1);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL str: got %h want %h", w_obs, exp_v);
            end
        end
    endtask

    task automatic test_pause_nop();
        Opcode   = 4'b1101;
        Continue = 1'b0;
        push_fetch();
        repeat (20) sb.push_back(c_LED);
        for (int ph = 0; ph < 3; ph++) begin
            while (sb.size() > 0) begin
                step();
                exp_v = sb.pop_front();
                n_checks++;
                if (w_obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL pause_phase%0d: got %h want %h", ph, w_obs, exp_v);
                end
            end
            if (ph == 0) begin
                Continue = 1'b1;
                repeat (3) sb.push_back(24'h0);
            end else if (ph == 1) begin
                Continue = 1'b0;
                sb.push_back(c_F1);
            end
        end
        Opcode = 4'b1111;
        push_fetch();
        sb.push_back(c_F1);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL nop: got %h want %h", w_obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        Opcode = 4'b0111;
        push_fetch();
        sb.push_back(c_GMARMUX | c_A1 | c_A2_OFF6 | c_SR1 | c_LDMAR);
        sb.push_back(c_ALUK_PASS | c_GALU | c_LDMDR);
        sb.push_back(c_WE);
        sb.push_back(c_WE);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL str_pre_reset: got %h want %h", w_obs, exp_v);
            end
        end
        #4;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (Mem_WE !== 1'b0 || w_obs !== 24'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", w_obs, 24'h0);
        end
        Run = 1'b0;
        step();
        step();
        Reset = 1'b0;
        repeat (3) sb.push_back(24'h0);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset_halt: got %h want %h", w_obs, exp_v);
            end
        end
        Run = 1'b1;
        sb.push_back(c_F1);
        while (sb.size() > 0) begin
            step();
            exp_v = sb.pop_front();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL restart_f1: got %h want %h", w_obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_alu(4'b0001, 1'b1, 24'h0);
        test_alu(4'b0101, 1'b0, c_ALUK_AND);
        test_alu(4'b1001, 1'b0, c_ALUK_NOT);
        test_branch(1'b0);
        test_branch(1'b1);
        test_jumps();
        test_ldr_str();
        test_pause_nop();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slc3_ctrl_fsm.md
Name: slc3_ctrl_fsm

Overview:
- Moore control-sequencer (ISDU) for the SLC-3 datapath inside slc3_testtop.
- Drives the datapath through fetch, decode and execute for the supported opcode subset.
- Asserts register loads, bus gates, mux selects and memory strobes each cycle.
- Handles the Run/Continue front-panel handshake and a configurable multi-cycle memory access.

Parameters:
MEM_WAIT, 3, cycles Mem_OE/Mem_WE is held per memory access (legal range 1..7).

Ports:
Clk  in  1  system clock, 50 MHz, rising edge
Reset  in  1  asynchronous, active-high; forces HALTED and all outputs 0
Run  in  1  level; leaves HALTED when 1
Continue  in  1  level; releases PAUSE states
Opcode  in  4  IR[15:12]
IR_5  in  1  IR[5], immediate select for ADD/AND
IR_11  in  1  IR[11], JSR vs JSRR
BEN  in  1  branch-enable flop from datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle
PCMUX  out  2  0=PC+1, 1=bus, 2=adder
DRMUX, SR1MUX, SR2MUX, ADDR1MUX  out  1 each  datapath selects
ADDR2MUX  out  2  0=zero, 1=off6, 2=off9, 3=off11
ALUK  out  2  0=ADD, 1=AND, 2=NOT, 3=PASSA
Mem_OE, Mem_WE  out  1 each  active-high SRAM strobes, never both high

Behaviour:
- Reset: state=HALTED, wait counter=0, every output 0. Asynchronous assert; deassertion takes effect at the next Clk edge.
- Reset mid-operation aborts instantly and drops any pending Mem_WE the same cycle.
- Outputs are a pure function of state and wait counter (Moore). Default value is 0 in every state.
- HALTED: all outputs 0. Run=1 moves to F1; otherwise stay.
- F1: GatePC, LD_MAR, LD_PC, PCMUX=0.
- F2: Mem_OE for MEM_WAIT cycles, tracked by a 3-bit counter. LD_MDR on the last of those cycles only.
- F3: GateMDR, LD_IR.
- DEC: LD_BEN, then dispatch on Opcode.
- ADD (0001) / AND (0101):
  - One cycle: GateALU, LD_REG, LD_CC, SR1MUX=1.
  - SR2MUX=IR_5; ALUK=0 for ADD, 1 for AND.
  - Then F1.
- NOT (1001): same shape as ADD/AND with ALUK=2.
- BR (0000): goes to BR_T if BEN=1, else F1. BR_T: PCMUX=2, ADDR2MUX=2, ADDR1MUX=0, LD_PC; then F1.
- JMP (1100): PCMUX=2, ADDR1MUX=1, ADDR2MUX=0, SR1MUX=1, LD_PC; then F1.
- JSR (0100):
  - J1: GatePC, DRMUX=1 (R7), LD_REG.
  - J2: IR_11=1 gives PCMUX=2, ADDR2MUX=3, ADDR1MUX=0; IR_11=0 gives PCMUX=2, ADDR2MUX=0, ADDR1MUX=1, SR1MUX=1.
  - J2 asserts LD_PC; then F1.
- LDR (0110):
  - L1: GateMARMUX, ADDR1MUX=1, ADDR2MUX=1, SR1MUX=1, LD_MAR.
  - L2: memory wait exactly as F2.
  - L3: GateMDR, LD_REG, LD_CC; then F1.
- STR (0111):
  - S1: same as L1.
  - S2: ALUK=3, SR1MUX=0, GateALU, LD_MDR.
  - S3: Mem_WE for MEM_WAIT cycles; then F1.
- PAUSE (1101):
  - P1: LD_LED; hold while Continue=0, move to P2 when Continue=1.
  - P2: hold while Continue=1, F1 when Continue=0. One instruction per press.
- Any other opcode: treated as NOP, DEC goes straight to F1.
- Run is ignored outside HALTED.
- Wait counter resets to 0 on entry to every memory state.

Test Plan:
- Reset=1 for 2 cycles, Run=0 -> state HALTED, every output 0, held for 10 cycles.
- Run=1, MEM_WAIT=3, Opcode=0001, IR_5=1 -> F1 (LD_PC=1, GatePC=1), then Mem_OE=1 for 3 cycles with LD_MDR only on the 3rd, then LD_IR, then LD_BEN, then GateALU=LD_REG=LD_CC=1 with SR2MUX=1. Back at F1 exactly 7 cycles after the first F1 cycle.
- Opcode=0000: with BEN=0 -> DEC goes to F1 and LD_PC stays 0. With BEN=1 -> one cycle of LD_PC=1, PCMUX=2, ADDR2MUX=2.
- Opcode=0111 -> S1 LD_MAR, S2 LD_MDR with ALUK=3, then Mem_WE=1 for 3 cycles with Mem_OE=0 throughout.
- Opcode=1101, Continue=0 for 20 cycles -> stays in P1 with LD_LED=1. Continue=1 -> P2. Continue=0 -> next cycle is F1.
- Reset pulsed during the 2nd Mem_WE cycle of STR -> Mem_WE=0 immediately, no clock required; HALTED after release; Run=1 restarts at F1.
